// File: rtl/uart_pkg.sv
// Shared UART definitions: data_len encodings, character mask helper,
// receive-FIFO entry width and idle-timeout length.
package uart_pkg;

    typedef enum logic [1:0] {
        LEN5 = 2'b00,
        LEN6 = 2'b01,
        LEN7 = 2'b10,
        LEN8 = 2'b11
    } data_len_e;

    localparam int RX_TIMEOUT_BITS = 40;  // four 10-bit character times
    localparam int RX_ENTRY_W      = 9;   // {parity_error, data[7:0]}

    function automatic logic [7:0] data_mask(input logic [1:0] len);
        case (data_len_e'(len))
            LEN5:    return 8'h1F;
            LEN6:    return 8'h3F;
            LEN7:    return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Idle counter for the receive FIFO: counts baud ticks while data sits unread
// and raises a sticky timeout after RX_TIMEOUT_BITS ticks with no activity.
module uart_rx_timeout
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic baud_tick,
    input  logic activity,
    input  logic empty,
    output logic timeout
);

    localparam logic [5:0] LAST_TICK = 6'(RX_TIMEOUT_BITS - 1);

    logic [5:0] idle_cnt;

    // The counter saturates at RX_TIMEOUT_BITS; timeout stays set until activity.
    always_ff @(posedge clk) begin
        if (!rst_n || activity || empty) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (baud_tick && !timeout) begin
            idle_cnt <= idle_cnt + 6'd1;
            if (idle_cnt == LAST_TICK) timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx with FWFT pop port, level/full/empty, sticky overrun
// and threshold interrupt. Define UART_RX_FIFO_TIMEOUT_EN to build the idle timeout.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              parity_error,
    input  logic [1:0]        data_len,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clr_overrun,
    input  logic [ADDR_W:0]   rx_thresh,
    output logic [7:0]        rd_data,
    output logic              rd_perr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overrun,
    output logic              rx_irq,
    output logic              rx_timeout
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [RX_ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [ADDR_W:0]       level_nxt;
    logic                  push_ok, pop_ok, drop;

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);

    // flush wins over both ports; a push into a full FIFO survives only with a pop.
    assign pop_ok  = rd_en && !empty && !flush;
    assign push_ok = rx_done && !flush && (!full || pop_ok);
    assign drop    = rx_done && !flush && !push_ok;

    always_comb begin
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else if (push_ok && !pop_ok)
            level_nxt = level + 1'b1;
        else if (pop_ok && !push_ok)
            level_nxt = level - 1'b1;
    end

    // NOTE: the storage array has no reset; pointers and level alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {parity_error, rx_data & data_mask(data_len)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
            rx_irq  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
            rx_irq <= (rx_thresh != '0) && (level_nxt >= rx_thresh);
        end
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr][7:0];
    assign rd_perr = empty ? 1'b0  : mem[rd_ptr][8];

`ifdef UART_RX_FIFO_TIMEOUT_EN
    uart_rx_timeout u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .activity  (push_ok || pop_ok || flush),
        .empty     (empty),
        .timeout   (rx_timeout)
    );
`else
    logic unused_baud_tick;
    assign unused_baud_tick = baud_tick;
    assign rx_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TO_TICKS = 40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              baud_tick;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              parity_error;
    logic [1:0]        data_len;
    logic              rd_en;
    logic              flush;
    logic              clr_overrun;
    logic [ADDR_W:0]   rx_thresh;
    logic [7:0]        rd_data;
    logic              rd_perr;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic              overrun;
    logic              rx_irq;
    logic              rx_timeout;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .data_len     (data_len),
        .rd_en        (rd_en),
        .flush        (flush),
        .clr_overrun  (clr_overrun),
        .rx_thresh    (rx_thresh),
        .rd_data      (rd_data),
        .rd_perr      (rd_perr),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .overrun      (overrun),
        .rx_irq       (rx_irq),
        .rx_timeout   (rx_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a queue of {perr, masked data} plus flag state.
    logic [8:0] q[$];
    bit         m_ovr, m_irq, m_to;
    int         m_idle;

    task automatic model_edge();
        int  n;
        bit  was_empty, pop_ok, push_ok, dropped;
        logic [7:0] mk;
        if (!rst_n) begin
            q.delete();
            m_ovr = 0; m_irq = 0; m_to = 0; m_idle = 0;
            return;
        end
        n         = q.size();
        was_empty = (n == 0);
        pop_ok    = rd_en && n > 0 && !flush;
        push_ok   = rx_done && !flush && (n < DEPTH || pop_ok);
        dropped   = rx_done && !flush && !push_ok;
        mk        = 8'((1 << (5 + int'(data_len))) - 1);
        if (flush) q.delete();
        else begin
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back({parity_error, rx_data & mk});
        end
        if (dropped) m_ovr = 1;
        else if (clr_overrun) m_ovr = 0;
        m_irq = (rx_thresh != 0) && (q.size() >= int'(rx_thresh));
`ifdef UART_RX_FIFO_TIMEOUT_EN
        if (flush || push_ok || pop_ok || was_empty) m_idle = 0;
        else if (baud_tick && m_idle < TO_TICKS) m_idle++;
        m_to = (m_idle == TO_TICKS);
`else
        m_to = 0;
`endif
    endtask

    task automatic compare_all();
        check("level",   32'(level),   32'(q.size()));
        check("empty",   32'(empty),   32'(q.size() == 0));
        check("full",    32'(full),    32'(q.size() == DEPTH));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("rx_irq",  32'(rx_irq),  32'(m_irq));
        check("rd_data", 32'(rd_data), q.size() ? 32'(q[0][7:0]) : 32'h0);
        check("rd_perr", 32'(rd_perr), q.size() ? 32'(q[0][8])   : 32'h0);
        check("rx_timeout", 32'(rx_timeout), 32'(m_to));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        rx_data = d; parity_error = p; rx_done = 1'b1;
        cycle();
        rx_done = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) push(base + 8'(i), 1'b0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; baud_tick = 1'b0; rx_data = 8'h00; rx_done = 1'b0;
        parity_error = 1'b0; data_len = 2'b11; rd_en = 1'b0; flush = 1'b0;
        clr_overrun = 1'b0; rx_thresh = '0;
        #2;
        cycle();
        cycle();
        rst_n = 1'b1;
        check("reset_level", 32'(level), 32'h0);
        check("reset_empty", 32'(empty), 32'h1);

        // Basic ordering and parity flag
        push(8'hA5, 1'b0);
        push(8'h5A, 1'b1);
        check("two_level", 32'(level), 32'h2);
        check("head_a5",   32'(rd_data), 32'hA5);
        check("head_perr0", 32'(rd_perr), 32'h0);
        pop();
        check("head_5a",   32'(rd_data), 32'h5A);
        check("head_perr1", 32'(rd_perr), 32'h1);
        pop();
        check("drained_empty", 32'(empty), 32'h1);
        check("drained_data",  32'(rd_data), 32'h0);

        // Character-length masking
        data_len = 2'b00;
        push(8'hFF, 1'b0);
        check("mask5", 32'(rd_data), 32'h1F);
        pop();
        data_len = 2'b10;
        push(8'hC3, 1'b0);
        check("mask7", 32'(rd_data), 32'h43);
        pop();
        data_len = 2'b11;

        // Overflow: 17th character dropped
        fill(17, 8'h00);
        check("ovf_full",    32'(full),    32'h1);
        check("ovf_level",   32'(level),   32'd16);
        check("ovf_overrun", 32'(overrun), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_seq", 32'(rd_data), 32'(i));
            pop();
        end
        check("ovf_drained", 32'(empty), 32'h1);
        clr_overrun = 1'b1;
        cycle();
        clr_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Push and pop together on a full FIFO
        fill(16, 8'h20);
        rd_en = 1'b1;
        push(8'h6D, 1'b0);
        rd_en = 1'b0;
        check("fullpp_level",   32'(level),   32'd16);
        check("fullpp_overrun", 32'(overrun), 32'h0);
        for (int i = 0; i < 15; i++) pop();
        check("fullpp_last", 32'(rd_data), 32'h6D);
        pop();
        // Push and pop together on an empty FIFO
        rd_en = 1'b1;
        push(8'h11, 1'b0);
        rd_en = 1'b0;
        check("emptypp_level", 32'(level), 32'h1);
        pop();

        // Threshold interrupt
        rx_thresh = 5'd4;
        fill(3, 8'h40);
        check("irq_below", 32'(rx_irq), 32'h0);
        push(8'h43, 1'b0);
        check("irq_at", 32'(rx_irq), 32'h1);
        pop();
        check("irq_after_pop", 32'(rx_irq), 32'h0);
        push(8'h44, 1'b0);
        rx_thresh = 5'd0;
        cycle();
        check("irq_disabled", 32'(rx_irq), 32'h0);
        do_flush();

`ifdef UART_RX_FIFO_TIMEOUT_EN
        // Idle timeout
        push(8'h77, 1'b0);
        for (int t = 1; t <= TO_TICKS; t++) begin
            cycle();
            baud_tick = 1'b1;
            cycle();
            baud_tick = 1'b0;
            if (t == TO_TICKS - 1) check("to_before", 32'(rx_timeout), 32'h0);
        end
        check("to_fired", 32'(rx_timeout), 32'h1);
        pop();
        check("to_cleared", 32'(rx_timeout), 32'h0);
`endif

        // flush overrides a push into a full FIFO
        fill(16, 8'h60);
        rx_done = 1'b1; rx_data = 8'hEE;
        do_flush();
        rx_done = 1'b0;
        check("flush_level",   32'(level),   32'h0);
        check("flush_overrun", 32'(overrun), 32'h0);

        // Randomized traffic in phases with different drain rates
        for (int ph = 0; ph < 4; ph++) begin
            int pop_pct;
            pop_pct = (ph == 0) ? 10 : (ph == 2) ? 90 : 50;
            for (int c = 0; c < 500; c++) begin
                rst_n        = ($urandom_range(0, 255) != 0);
                rx_done      = ($urandom_range(0, 99) < 55);
                rx_data      = 8'($urandom);
                parity_error = 1'($urandom);
                data_len     = 2'($urandom);
                rd_en        = ($urandom_range(0, 99) < pop_pct);
                flush        = ($urandom_range(0, 63) == 0);
                clr_overrun  = ($urandom_range(0, 15) == 0);
                baud_tick    = 1'($urandom);
                if ($urandom_range(0, 31) == 0) rx_thresh = (ADDR_W + 1)'($urandom_range(0, DEPTH));
                cycle();
            end
        end
        rst_n = 1'b1; rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0;
        clr_overrun = 1'b0; baud_tick = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
